// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 256x8 synchronous-read memory between the
// processor (port 0) and a debug/loader port (port 1). Accesses are
// serialised through IDLE -> ISSUE (-> RDATA) -> IDLE, with a one-cycle
// grant pulse in ISSUE and a one-cycle read-valid pulse in RDATA.
// Ties go round-robin, or always to port 1 when FIXED_PRI is set.
module mem_arbiter #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [1:0] req,
  input  logic [1:0] we,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic [1:0] rvalid,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RDATA = 2'b10
  } arbState_t;

  arbState_t  r_state;
  arbState_t  w_nextState;

  logic       r_cmdWe;
  logic [7:0] r_cmdAddr;
  logic [7:0] r_cmdWdata;
  logic       r_owner;
  logic       r_lastGrant;
  logic [7:0] r_rdata;

  logic       w_accept;
  logic       w_winner;
  logic [1:0] w_ownerOneHot;

  // A request is only taken while idle; busy states ignore req entirely.
  assign w_accept = (r_state == IDLE) && (req != 2'b00);

  // One-hot form of the current owner, shared by the grant and valid pulses.
  assign w_ownerOneHot = r_owner ? 2'b10 : 2'b01;

  // The memory address and write data come straight from the latched command,
  // so they hold their last values between transactions.
  assign mem_addr  = r_cmdAddr;
  assign mem_wdata = r_cmdWdata;

  // Pick the winning port: a lone requester wins, a tie goes to port 1 under
  // fixed priority, otherwise to whichever port was not granted last.
  always_comb begin
    w_winner = 1'b0;
    case (req)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = FIXED_PRI ? 1'b1 : ~r_lastGrant;
      default: w_winner = 1'b0;
    endcase
  end

  // State register; reset drops straight back to IDLE, abandoning any command.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: writes finish after ISSUE, reads spend one more cycle
  // in RDATA while the memory's registered output is presented.
  always_comb begin
    w_nextState = IDLE;
    case (r_state)
      IDLE:    w_nextState = w_accept ? ISSUE : IDLE;
      ISSUE:   w_nextState = r_cmdWe ? IDLE : RDATA;
      RDATA:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Latch the winner's command and remember it for the round-robin tie-break.
  // last_grant starts at 1 so port 0 wins the first tie after reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cmdWe     <= 1'b0;
      r_cmdAddr   <= 8'h00;
      r_cmdWdata  <= 8'h00;
      r_owner     <= 1'b0;
      r_lastGrant <= 1'b1;
    end else if (w_accept) begin
      r_cmdWe     <= we[w_winner];
      r_cmdAddr   <= w_winner ? addr1 : addr0;
      r_cmdWdata  <= w_winner ? wdata1 : wdata0;
      r_owner     <= w_winner;
      r_lastGrant <= w_winner;
    end
  end

  // Capture the read data on the way out of RDATA so rdata keeps showing it.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rdata <= 8'h00;
    end else if (r_state == RDATA) begin
      r_rdata <= mem_rdata;
    end
  end

  // Outputs decode from the state alone, so reset clears them immediately
  // without waiting for a clock edge; read and write strobes are exclusive.
  always_comb begin
    gnt       = 2'b00;
    rvalid    = 2'b00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = 1'b0;
    rdata     = r_rdata;
    case (r_state)
      ISSUE: begin
        gnt       = w_ownerOneHot;
        mem_write = r_cmdWe;
        mem_read  = ~r_cmdWe;
        busy      = 1'b1;
      end
      RDATA: begin
        rvalid = w_ownerOneHot;
        rdata  = mem_rdata;
        busy   = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Two instances share the
// requester inputs: one round-robin, one fixed-priority. Each has its own
// 256x8 synchronous-read memory model. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_mem_arbiter;

  logic       clk;
  logic       rstN;
  logic [1:0] req;
  logic [1:0] we;
  logic [7:0] addr0, addr1, wdata0, wdata1;

  logic [1:0] gnt, rvalid;
  logic [7:0] rdata, memAddr, memWdata, memRdata;
  logic       busy, memRead, memWrite;

  logic [1:0] gntFp, rvalidFp;
  logic [7:0] rdataFp, memAddrFp, memWdataFp, memRdataFp;
  logic       busyFp, memReadFp, memWriteFp;

  logic [7:0] memArr   [256];
  logic [7:0] memArrFp [256];

  logic       tbLoadEn;
  logic [7:0] tbLoadAddr, tbLoadData;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.FIXED_PRI(1'b0)) dutRr (
    .CLOCK_50(clk), .RESET_N(rstN), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .mem_read(memRead), .mem_write(memWrite), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_rdata(memRdata)
  );

  mem_arbiter #(.FIXED_PRI(1'b1)) dutFp (
    .CLOCK_50(clk), .RESET_N(rstN), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gntFp), .rvalid(rvalidFp), .rdata(rdataFp), .busy(busyFp),
    .mem_read(memReadFp), .mem_write(memWriteFp), .mem_addr(memAddrFp),
    .mem_wdata(memWdataFp), .mem_rdata(memRdataFp)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory models: write and registered read on the rising edge, plus a
  // back-door load port used to preset contents while the arbiter is idle.
  always @(posedge clk) begin
    if (memWrite) memArr[memAddr] <= memWdata;
    else if (tbLoadEn) memArr[tbLoadAddr] <= tbLoadData;
    if (memRead) memRdata <= memArr[memAddr];
  end

  always @(posedge clk) begin
    if (memWriteFp) memArrFp[memAddrFp] <= memWdataFp;
    else if (tbLoadEn) memArrFp[tbLoadAddr] <= tbLoadData;
    if (memReadFp) memRdataFp <= memArrFp[memAddrFp];
  end

  // Hang guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
    req    = r;
    we     = w;
    addr0  = a0;
    addr1  = a1;
    wdata0 = d0;
    wdata1 = d1;
  endtask

  task automatic loadMem(input logic [7:0] a, input logic [7:0] d);
    tbLoadEn   = 1'b1;
    tbLoadAddr = a;
    tbLoadData = d;
    @(negedge clk);
    tbLoadEn   = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".gnt"},       gnt,      2'b00);
    checkOutput({tag, ".rvalid"},    rvalid,   2'b00);
    checkOutput({tag, ".rdata"},     rdata,    8'h00);
    checkOutput({tag, ".busy"},      busy,     1'b0);
    checkOutput({tag, ".memRead"},   memRead,  1'b0);
    checkOutput({tag, ".memWrite"},  memWrite, 1'b0);
    checkOutput({tag, ".memAddr"},   memAddr,  8'h00);
    checkOutput({tag, ".memWdata"},  memWdata, 8'h00);
    checkOutput({tag, ".fpGnt"},     gntFp,    2'b00);
    checkOutput({tag, ".fpBusy"},    busyFp,   1'b0);
  endtask

  task automatic checkInvariants(input string tag);
    checkOutput({tag, ".collide"},   32'(memRead & memWrite), 32'd0);
    checkOutput({tag, ".gntOh"},     32'($onehot0(gnt)), 32'd1);
    checkOutput({tag, ".rvalidOh"},  32'($onehot0(rvalid)), 32'd1);
    checkOutput({tag, ".busyState"}, busy, |{gnt, rvalid});
    checkOutput({tag, ".fpCollide"}, 32'(memReadFp & memWriteFp), 32'd0);
    checkOutput({tag, ".fpBusy"},    busyFp, |{gntFp, rvalidFp});
  endtask

  task automatic pulseReset();
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // Directed sequence followed by a short constrained-random run.
  initial begin
    logic       tbLast;
    logic       winner;
    logic [1:0] r, w;
    logic [7:0] a0, a1, d0, d1, expAddr, expData, expRead;
    logic       expWe;

    rstN = 1'b1;
    tbLoadEn = 1'b0;
    tbLoadAddr = 8'h00;
    tbLoadData = 8'h00;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #2 rstN = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");

    loadMem(8'h20, 8'h11);
    loadMem(8'h30, 8'h22);
    loadMem(8'h05, 8'h3C);
    rstN = 1'b1;

    // Port 0 write 0xA5 to 0x10, then read it back.
    applyStimulus(2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00);
    @(negedge clk);
    checkOutput("wr.gnt",      gnt,      2'b01);
    checkOutput("wr.memWrite", memWrite, 1'b1);
    checkOutput("wr.memRead",  memRead,  1'b0);
    checkOutput("wr.memAddr",  memAddr,  8'h10);
    checkOutput("wr.memWdata", memWdata, 8'hA5);
    checkOutput("wr.busy",     busy,     1'b1);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("wr.idleBusy", busy,     1'b0);
    checkOutput("wr.idleGnt",  gnt,      2'b00);
    checkOutput("wr.idleMw",   memWrite, 1'b0);
    checkOutput("wr.mem10",    memArr[8'h10], 8'hA5);

    applyStimulus(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rd.gnt",      gnt,      2'b01);
    checkOutput("rd.memRead",  memRead,  1'b1);
    checkOutput("rd.memWrite", memWrite, 1'b0);
    checkOutput("rd.rvalidIss", rvalid,  2'b00);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rd.rvalid",   rvalid,   2'b01);
    checkOutput("rd.rdata",    rdata,    8'hA5);
    @(negedge clk);
    checkOutput("rd.rvalidOff", rvalid,  2'b00);
    checkOutput("rd.rdataHeld", rdata,   8'hA5);
    checkOutput("rd.busyOff",  busy,     1'b0);

    // Both ports reading continuously: round-robin alternates, fixed
    // priority always serves port 1.
    pulseReset();
    applyStimulus(2'b11, 2'b00, 8'h20, 8'h30, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      winner = (k % 2 == 1);
      @(negedge clk);
      checkOutput($sformatf("rr%0d.gnt", k),     gnt,     winner ? 2'b10 : 2'b01);
      checkOutput($sformatf("rr%0d.memAddr", k), memAddr, winner ? 8'h30 : 8'h20);
      checkOutput($sformatf("fp%0d.gnt", k),     gntFp,   2'b10);
      @(negedge clk);
      checkOutput($sformatf("rr%0d.rvalid", k),  rvalid,   winner ? 2'b10 : 2'b01);
      checkOutput($sformatf("rr%0d.rdata", k),   rdata,    winner ? 8'h22 : 8'h11);
      checkOutput($sformatf("fp%0d.rvalid", k),  rvalidFp, 2'b10);
      checkOutput($sformatf("fp%0d.rdata", k),   rdataFp,  8'h22);
      @(negedge clk);
      checkOutput($sformatf("rr%0d.idle", k),    busy,   1'b0);
      checkOutput($sformatf("fp%0d.idleGnt", k), gntFp,  2'b00);
      if (k == 3) applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    end

    // Reset during ISSUE of a write must keep the write out of memory.
    applyStimulus(2'b01, 2'b01, 8'h05, 8'h00, 8'hFF, 8'h00);
    @(negedge clk);
    checkOutput("rst.gnt",      gnt,      2'b01);
    checkOutput("rst.memWrite", memWrite, 1'b1);
    rstN = 1'b0;
    #1;
    checkResetValues("rstMid");
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rst.mem05", memArr[8'h05], 8'h3C);
    checkOutput("rst.rvalid", rvalid, 2'b00);
    rstN = 1'b1;
    applyStimulus(2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rst.rdGnt", gnt, 2'b01);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rst.rdValid", rvalid, 2'b01);
    checkOutput("rst.rdData",  rdata,  8'h3C);
    @(negedge clk);

    // Port 0 holds req across two reads, changing addr after the first grant.
    applyStimulus(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("hold1.gnt",     gnt,     2'b01);
    checkOutput("hold1.memAddr", memAddr, 8'h10);
    applyStimulus(2'b01, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("hold1.rvalid",  rvalid,  2'b01);
    checkOutput("hold1.rdata",   rdata,   8'hA5);
    @(negedge clk);
    checkOutput("hold.idle",     busy,    1'b0);
    @(negedge clk);
    checkOutput("hold2.gnt",     gnt,     2'b01);
    checkOutput("hold2.memAddr", memAddr, 8'h20);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("hold2.rvalid",  rvalid,  2'b01);
    checkOutput("hold2.rdata",   rdata,   8'h11);
    @(negedge clk);

    // Random traffic against a small round-robin model.
    pulseReset();
    tbLast = 1'b1;
    for (int t = 0; t < 30; t++) begin
      r  = 2'($urandom_range(1, 3));
      w  = 2'($urandom_range(0, 3));
      a0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255));
      d0 = 8'($urandom_range(0, 255));
      d1 = 8'($urandom_range(0, 255));
      if (r == 2'b01)      winner = 1'b0;
      else if (r == 2'b10) winner = 1'b1;
      else                 winner = ~tbLast;
      tbLast  = winner;
      expWe   = w[winner];
      expAddr = winner ? a1 : a0;
      expData = winner ? d1 : d0;
      applyStimulus(r, w, a0, a1, d0, d1);
      @(negedge clk);
      checkOutput($sformatf("rnd%0d.gnt", t),      gnt,      winner ? 2'b10 : 2'b01);
      checkOutput($sformatf("rnd%0d.memAddr", t),  memAddr,  expAddr);
      checkOutput($sformatf("rnd%0d.memWrite", t), memWrite, expWe);
      checkInvariants($sformatf("rnd%0d.iss", t));
      expRead = memArr[expAddr];
      applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      if (!expWe) begin
        @(negedge clk);
        checkOutput($sformatf("rnd%0d.rvalid", t), rvalid, winner ? 2'b10 : 2'b01);
        checkOutput($sformatf("rnd%0d.rdata", t),  rdata,  expRead);
        checkInvariants($sformatf("rnd%0d.rd", t));
      end
      @(negedge clk);
      checkOutput($sformatf("rnd%0d.idle", t), busy, 1'b0);
      checkInvariants($sformatf("rnd%0d.idl", t));
      if (expWe) checkOutput($sformatf("rnd%0d.mem", t), memArr[expAddr], expData);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
